// File: rtl/bcast_fifo_two.sv
// bcast_fifo_two: single-writer, dual-reader broadcast FIFO.
// One producer enqueues words. Readers A and B each see every word, in order,
// and consume at their own rate. A slot is reused only after both readers
// have dequeued it, so the slower reader governs fullness.
module bcast_fifo_two #(
    parameter int width   = 1,
    parameter int log2dep = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    input  logic             CLR,
    output logic [width-1:0] D_OUT_A,
    output logic             EMPTY_N_A,
    input  logic             DEQ_A,
    output logic [width-1:0] D_OUT_B,
    output logic             EMPTY_N_B,
    input  logic             DEQ_B
);

    localparam int DEPTH = 1 << log2dep;
    localparam int PW    = log2dep + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // Pointers carry one extra MSB so that "depth outstanding" differs from "empty".
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    ra_q, ra_d;
    logic [PW-1:0]    rb_q, rb_d;
    logic [PW-1:0]    cnt_a, cnt_b;
    logic [width-1:0] mem_q [DEPTH];

    logic enq_ok, deq_a_ok, deq_b_ok;

    // Occupancy per reader and the handshake qualifiers derived from it
    always_comb begin
        cnt_a     = wp_q - ra_q;
        cnt_b     = wp_q - rb_q;
        EMPTY_N_A = (cnt_a != '0);
        EMPTY_N_B = (cnt_b != '0);
        // FULL_N is forced low for as long as reset is asserted.
        FULL_N    = RST_N && (cnt_a != DEPTH_P) && (cnt_b != DEPTH_P);
        enq_ok    = ENQ   && FULL_N;
        deq_a_ok  = DEQ_A && EMPTY_N_A;
        deq_b_ok  = DEQ_B && EMPTY_N_B;
    end

    // Next pointer values; clear wins over every strobe in the same cycle
    always_comb begin
        wp_d = wp_q;
        ra_d = ra_q;
        rb_d = rb_q;
        if (CLR) begin
            wp_d = '0;
            ra_d = '0;
            rb_d = '0;
        end else begin
            if (enq_ok)   wp_d = wp_q + ONE_P;
            if (deq_a_ok) ra_d = ra_q + ONE_P;
            if (deq_b_ok) rb_d = rb_q + ONE_P;
        end
    end

    // Pointer registers, cleared asynchronously by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else begin
            wp_q <= wp_d;
            ra_q <= ra_d;
            rb_q <= rb_d;
        end
    end

    // Storage array; contents are never reset, only the pointers are
    always_ff @(posedge CLK) begin
        if (enq_ok && !CLR) begin
            mem_q[wp_q[log2dep-1:0]] <= D_IN;
        end
    end

    // Head words come straight from the registered read pointers (no bypass)
    always_comb begin
        D_OUT_A = mem_q[ra_q[log2dep-1:0]];
        D_OUT_B = mem_q[rb_q[log2dep-1:0]];
    end

endmodule
